// File: rtl/conv_result_fifo_if.sv
// Handshake bundle between the convolution controller/host and the
// result FIFO: command, write data, drain stream and status.
interface conv_result_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [1:0]            fifo_command;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_out_valid;
   logic                  data_out_ready;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  drain_done;
   logic                  overflow;
   logic                  cmd_error;

   modport master (
      output fifo_command,
      output data_in,
      output data_out_ready,
      input  data_out,
      input  data_out_valid,
      input  full,
      input  empty,
      input  count,
      input  drain_done,
      input  overflow,
      input  cmd_error
   );

   modport slave (
      input  fifo_command,
      input  data_in,
      input  data_out_ready,
      output data_out,
      output data_out_valid,
      output full,
      output empty,
      output count,
      output drain_done,
      output overflow,
      output cmd_error
   );
endinterface

// File: rtl/conv_result_fifo.sv
// Result buffer behind the convolution datapath: edge-qualified commands
// fill it one word per write, and a read drains it over valid/ready.
module conv_result_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input logic               clk,
   input logic               reset,
   conv_result_fifo_if.slave bus
);
   localparam logic [1:0] CMD_WR = 2'b10;
   localparam logic [1:0] CMD_RD = 2'b01;
   localparam logic [1:0] CMD_FL = 2'b11;

   localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   typedef enum logic {
      S_FILL,
      S_DRAIN
   } state_t;

   state_t                state_q;
   logic [1:0]            cmd_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  valid_q;
   logic                  drain_done_q;
   logic                  overflow_q;
   logic                  cmd_error_q;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  cmd_edge;
   logic                  wr_ev;
   logic                  rd_ev;
   logic                  fl_ev;
   logic                  is_full;
   logic                  xfer;
   logic                  load;
   logic                  last_xfer;
   logic                  mem_we;
   logic [ADDR_WIDTH:0]   vld_ext;
   logic [ADDR_WIDTH:0]   remain;

   // A held command must not repeat its action.
   assign cmd_edge = (bus.fifo_command != cmd_q);
   assign wr_ev    = cmd_edge && (bus.fifo_command == CMD_WR);
   assign rd_ev    = cmd_edge && (bus.fifo_command == CMD_RD);
   assign fl_ev    = cmd_edge && (bus.fifo_command == CMD_FL);

   assign is_full  = (count_q == FULL_CNT);
   assign xfer     = valid_q && bus.data_out_ready;
   assign last_xfer = xfer && (count_q == CNT_ONE);

   // count includes the output register, so exclude it for unread words.
   assign vld_ext  = {{ADDR_WIDTH{1'b0}}, valid_q};
   assign remain   = count_q - vld_ext;
   assign load     = (state_q == S_DRAIN) && !fl_ev
                   && (!valid_q || bus.data_out_ready)
                   && (remain != '0);

   assign mem_we   = (state_q == S_FILL) && wr_ev && !is_full;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_FILL;
         cmd_q        <= 2'b00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         valid_q      <= 1'b0;
         drain_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         cmd_error_q  <= 1'b0;
      end else begin
         cmd_q        <= bus.fifo_command;
         drain_done_q <= 1'b0;
         unique case (state_q)
            S_FILL: begin
               if (fl_ev) begin
                  wr_ptr_q    <= '0;
                  rd_ptr_q    <= '0;
                  count_q     <= '0;
                  overflow_q  <= 1'b0;
                  cmd_error_q <= 1'b0;
               end else if (wr_ev) begin
                  if (!is_full) begin
                     wr_ptr_q <= wr_ptr_q + PTR_ONE;
                     count_q  <= count_q + CNT_ONE;
                  end else begin
                     overflow_q <= 1'b1;
                  end
               end else if (rd_ev) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fl_ev) begin
                  valid_q     <= 1'b0;
                  wr_ptr_q    <= '0;
                  rd_ptr_q    <= '0;
                  count_q     <= '0;
                  overflow_q  <= 1'b0;
                  cmd_error_q <= 1'b0;
                  state_q     <= S_FILL;
               end else begin
                  if (wr_ev) begin
                     cmd_error_q <= 1'b1;
                  end
                  if (xfer) begin
                     count_q <= count_q - CNT_ONE;
                  end
                  if (load) begin
                     data_out_q <= mem_q[rd_ptr_q];
                     rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                     valid_q    <= 1'b1;
                  end else if (xfer) begin
                     valid_q <= 1'b0;
                  end
                  // Finished: last word taken, or nothing to drain at all.
                  if (last_xfer || (!valid_q && count_q == '0)) begin
                     drain_done_q <= 1'b1;
                     state_q      <= S_FILL;
                  end
               end
            end
            default: state_q <= S_FILL;
         endcase
      end
   end

   assign bus.data_out       = data_out_q;
   assign bus.data_out_valid = valid_q;
   assign bus.count          = count_q;
   assign bus.full           = is_full;
   assign bus.empty          = (count_q == '0);
   assign bus.drain_done     = drain_done_q;
   assign bus.overflow       = overflow_q;
   assign bus.cmd_error      = cmd_error_q;
endmodule
